// File: rtl/led_arbiter_pkg.sv
// Shared constants, FSM encoding and round-robin pick helper for led_arbiter.
package led_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 2;
    localparam int GAP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // First set bit at or after last+1, wrapping; the entry at last itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] idx;
        rr_pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + IDX_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/led_arbiter_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, one per request line.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin LED arbiter with minimum hold and inter-grant gap.
// Optional preemption of long grants when LED_ARBITER_TIMEOUT_EN is defined.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int HOLD_MIN   = 4,
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    output logic [3:0]   grant,
    output logic         busy,
    output logic [1:0]   owner
);

    if (HOLD_MIN < 1 || HOLD_MIN > HOLD_MAX || HOLD_MAX > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_params
        $error("led_arbiter: illegal HOLD_MIN/HOLD_MAX/GAP_CYCLES");
    end

    logic [NUM_REQ-1:0] req_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
        sync2 u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (req[g]),
            .q_o   (req_s[g])
        );
    end

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GAP_W-1:0]   gap_q;

    logic [IDX_W-1:0]   pick_d;
    logic               hold_done_d;
    logic               preempt_d;
    logic               release_d;

    assign pick_d      = rr_pick(req_s, last_q);
    assign hold_done_d = (cnt_q >= CNT_W'(HOLD_MIN - 1));

`ifdef LED_ARBITER_TIMEOUT_EN
    assign preempt_d = (cnt_q == CNT_W'(HOLD_MAX - 1)) &&
                       (|(req_s & ~(NUM_REQ'(1) << owner_q)));
`else
    assign preempt_d = 1'b0;
`endif

    assign release_d = (~req_s[owner_q] && hold_done_d) || preempt_d;

    // The IDLE cycle itself is the last zero cycle of the gap, so GAP lasts GAP_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_s) begin
                        grant_q <= NUM_REQ'(1) << pick_d;
                        busy_q  <= 1'b1;
                        owner_q <= pick_d;
                        last_q  <= pick_d;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_d) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        gap_q   <= '0;
                        state_q <= (GAP_CYCLES == 1) ? ST_IDLE : ST_GAP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 2)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter against a timestamp-based round-robin reference model.
module tb_led_arbiter;

    localparam int HOLD_MIN   = 4;
    localparam int HOLD_MAX   = 16;
    localparam int GAP_CYCLES = 2;
`ifdef LED_ARBITER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    led_arbiter #(
        .HOLD_MIN   (HOLD_MIN),
        .HOLD_MAX   (HOLD_MAX),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    // Reference model: requests seen two edges late, grant ages, next arbitration by timestamp.
    logic [3:0] m_d1, m_d2, m_rs, m_grant;
    logic [1:0] m_owner;
    int         m_last, m_age, m_cyc, m_next_arb;
    bit         m_active, m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = 0; m_d2 = 0; m_rs = 0; m_grant = 0; m_owner = 0;
            m_last = 3; m_age = 0; m_cyc = 0; m_next_arb = 0; m_active = 0;
        end else begin
            m_rs = m_d2; m_d2 = m_d1; m_d1 = req;
            m_cyc++;
            if (m_active) begin
                if ((!m_rs[m_owner] && m_age >= HOLD_MIN - 1) ||
                    (TMO && m_age == HOLD_MAX - 1 && (m_rs & ~(4'b0001 << m_owner)) != 0)) begin
                    m_active   = 0;
                    m_grant    = 0;
                    m_next_arb = m_cyc + GAP_CYCLES;
                end else if (m_age < 255) begin
                    m_age++;
                end
            end else if (m_cyc >= m_next_arb && m_rs != 0) begin
                m_found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!m_found && m_rs[(m_last + k) % 4]) begin
                        m_found = 1;
                        m_last  = (m_last + k) % 4;
                    end
                end
                m_owner  = 2'(m_last);
                m_grant  = 4'b0001 << m_last;
                m_active = 1;
                m_age    = 0;
            end
        end
    end

    // Structural invariant on every cycle: one-hot-or-zero grant, busy mirrors it.
    always @(negedge clk) begin
        if (chk_on) begin
            n_tests++;
            if (((grant & (grant - 4'd1)) !== 4'd0) || (busy !== (|grant))) begin
                n_fail++;
                $display("FAIL invariant t=%0t grant=%b busy=%b required one-hot-or-zero and busy=|grant",
                         $time, grant, busy);
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({grant, busy, owner} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state got grant=%b busy=%b owner=%0d required all zero", grant, busy, owner);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({grant, busy, owner} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_idle got grant=%b busy=%b owner=%0d required all zero", grant, busy, owner);
        end
    endtask

    task automatic test_single_pulse;
        logic [3:0] exp_g [1:8];
        exp_g = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        do_reset;
        req = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req = 4'b0000;
            n_tests++;
            if (grant !== exp_g[c] || (c >= 3 && owner !== 2'd1)) begin
                n_fail++;
                $display("FAIL pulse_seq cycle %0d got grant=%b owner=%0d required grant=%b owner=1",
                         c, grant, owner, exp_g[c]);
            end
            n_tests++;
            if ({grant, busy, owner} !== {m_grant, |m_grant, m_owner}) begin
                n_fail++;
                $display("FAIL pulse_model cycle %0d got %b/%b/%0d required %b/%b/%0d",
                         c, grant, busy, owner, m_grant, |m_grant, m_owner);
            end
        end
    endtask

    // Each owner drops its request once granted and re-raises it when released.
    task automatic test_round_robin;
        logic [3:0] seq [5];
        logic [3:0] prev;
        int ng, run;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset;
        ng = 0; run = 0; prev = 4'b0000;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            req = ~grant;
            @(negedge clk);
            n_tests++;
            if ({grant, busy, owner} !== {m_grant, |m_grant, m_owner}) begin
                n_fail++;
                $display("FAIL rr_model cycle %0d got %b/%b/%0d required %b/%b/%0d",
                         c, grant, busy, owner, m_grant, |m_grant, m_owner);
            end
            if (grant !== prev) begin
                if (prev != 4'b0000 && ng <= 5) begin
                    n_tests++;
                    if (run != HOLD_MIN) begin
                        n_fail++;
                        $display("FAIL rr_hold grant %b held %0d required %0d", prev, run, HOLD_MIN);
                    end
                end else if (prev == 4'b0000 && ng > 0 && ng < 5) begin
                    n_tests++;
                    if (run != GAP_CYCLES) begin
                        n_fail++;
                        $display("FAIL rr_gap gap %0d cycles required %0d", run, GAP_CYCLES);
                    end
                end
                if (grant != 4'b0000) begin
                    if (ng < 5) begin
                        n_tests++;
                        if (grant !== seq[ng]) begin
                            n_fail++;
                            $display("FAIL rr_order grant #%0d got %b required %b", ng, grant, seq[ng]);
                        end
                    end
                    ng++;
                end
                run  = 1;
                prev = grant;
            end else begin
                run++;
            end
        end
        n_tests++;
        if (ng < 5) begin
            n_fail++;
            $display("FAIL rr_timeout saw %0d grants required 5", ng);
        end
        req = 4'b0000;
    endtask

    // req[0] held, req[2] joins on the 5th grant cycle.
    task automatic test_long_hold;
        int run, zeros, waited;
        do_reset;
        req = 4'b0001;
        waited = 0;
        while (grant !== 4'b0001 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (grant !== 4'b0001 || waited != 3) begin
            n_fail++;
            $display("FAIL hold_first got grant=%b after %0d cycles required 0001 after 3", grant, waited);
        end
        run = 1;
        while (grant === 4'b0001 && run < 110) begin
            if (run == 5) req = 4'b0101;
`ifndef LED_ARBITER_TIMEOUT_EN
            if (run == 100) req = 4'b0100;
`endif
            @(negedge clk);
            n_tests++;
            if ({grant, busy, owner} !== {m_grant, |m_grant, m_owner}) begin
                n_fail++;
                $display("FAIL hold_model run %0d got %b/%b/%0d required %b/%b/%0d",
                         run, grant, busy, owner, m_grant, |m_grant, m_owner);
            end
            if (grant === 4'b0001) run++;
        end
        n_tests++;
`ifdef LED_ARBITER_TIMEOUT_EN
        if (run != HOLD_MAX) begin
            n_fail++;
            $display("FAIL hold_preempt grant[0] held %0d cycles required %0d", run, HOLD_MAX);
        end
`else
        if (run < 100) begin
            n_fail++;
            $display("FAIL hold_no_preempt grant[0] held %0d cycles required at least 100", run);
        end
`endif
        zeros = 0;
        while (grant === 4'b0000 && zeros < 12) begin
            @(negedge clk);
            zeros++;
        end
        n_tests++;
        if (grant !== 4'b0100 || (TMO && zeros != GAP_CYCLES)) begin
            n_fail++;
            $display("FAIL hold_next got grant=%b after %0d zero cycles required 0100", grant, zeros);
        end
        req = 4'b0000;
    endtask

`ifdef LED_ARBITER_TIMEOUT_EN
    task automatic test_constant_all;
        logic [3:0] seq [5];
        logic [3:0] prev;
        int ng;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset;
        req = 4'b1111;
        ng = 0; prev = 4'b0000;
        for (int c = 0; c < 120 && ng < 5; c++) begin
            @(negedge clk);
            if (grant !== prev && grant !== 4'b0000) begin
                n_tests++;
                if (grant !== seq[ng]) begin
                    n_fail++;
                    $display("FAIL const_order grant #%0d got %b required %b", ng, grant, seq[ng]);
                end
                ng++;
            end
            prev = grant;
        end
        n_tests++;
        if (ng < 5) begin
            n_fail++;
            $display("FAIL const_timeout saw %0d grants required 5", ng);
        end
        req = 4'b0000;
    endtask
`endif

    task automatic test_async_reset;
        int waited;
        do_reset;
        req = 4'b0100;
        waited = 0;
        while (grant === 4'b0000 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        chk_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || waited >= 10) begin
            n_fail++;
            $display("FAIL async_reset got grant=%b busy=%b (waited %0d) required 0/0 before next edge",
                     grant, busy, waited);
        end
        req = 4'b0000;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        req    = 4'b1001;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (grant !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL async_first cycle %0d got grant=%b required %b",
                         c, grant, (c == 3) ? 4'b0001 : 4'b0000);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_random;
        do_reset;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            @(negedge clk);
            n_tests++;
            if ({grant, busy, owner} !== {m_grant, |m_grant, m_owner}) begin
                n_fail++;
                $display("FAIL random_model cycle %0d req=%b got %b/%b/%0d required %b/%b/%0d",
                         c, req, grant, busy, owner, m_grant, |m_grant, m_owner);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_single_pulse;
        test_round_robin;
        test_long_hold;
`ifdef LED_ARBITER_TIMEOUT_EN
        test_constant_all;
`endif
        test_async_reset;
        test_random;
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
